// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control unit: state sequencer, ALU decode, flags and condition logic
module mc_controller #(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_r_q, condex_r_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  logic mem_rdy;
  assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  // Condition evaluated against the stored {N,Z,C,V}
  logic cond_ex;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = flags_q[2];
      4'h1: cond_ex = ~flags_q[2];
      4'h2: cond_ex = flags_q[1];
      4'h3: cond_ex = ~flags_q[1];
      4'h4: cond_ex = flags_q[3];
      4'h5: cond_ex = ~flags_q[3];
      4'h6: cond_ex = flags_q[0];
      4'h7: cond_ex = ~flags_q[0];
      4'h8: cond_ex = flags_q[1] & ~flags_q[2];
      4'h9: cond_ex = ~flags_q[1] | flags_q[2];
      4'hA: cond_ex = (flags_q[3] == flags_q[0]);
      4'hB: cond_ex = (flags_q[3] != flags_q[0]);
      4'hC: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic [2:0] alu_op;
  logic       is_cmp, is_arith;
  always_comb begin
    alu_op = 3'd0;
    case (funct[4:1])
      4'b0100: alu_op = 3'd0;
      4'b0010: alu_op = 3'd1;
      4'b0000: alu_op = 3'd2;
      4'b1100: alu_op = 3'd3;
      4'b0001: alu_op = 3'd4;
      4'b1010: alu_op = 3'd1;
      default: alu_op = 3'd0;
    endcase
  end
  assign is_cmp   = (funct[4:1] == 4'b1010);
  assign is_arith = (funct[4:1] == 4'b0100) | (funct[4:1] == 4'b0010) | is_cmp;

  logic mem_req, ir_write, fetch_adv, reg_w, mem_w, branch, exec;
  always_comb begin
    state_d   = S_FETCH;
    mem_req   = 1'b0;
    ir_write  = 1'b0;
    fetch_adv = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    exec      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ImmSrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_rdy) begin
          ir_write  = 1'b1;
          fetch_adv = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        exec    = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        exec    = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_w = ~is_cmp;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // CMP always rewrites all four flags regardless of its S bit
  logic [1:0] flag_w;
  assign flag_w = !exec  ? 2'b00 :
                  is_cmp ? 2'b11 : {funct[0], funct[0] & is_arith};

  always_comb begin
    flags_d = flags_q;
    if (condex_r_q) begin
      if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  assign condex_r_d = (state_q == S_DECODE) ? cond_ex : condex_r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      flags_q    <= 4'b0000;
      condex_r_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      condex_r_q <= condex_r_d;
    end
  end

  // Strobes are gated by reset so FETCH's request is not seen while held in reset
  assign MemReq     = reset & mem_req;
  assign IRWrite    = reset & ir_write;
  assign PCWrite    = reset & (fetch_adv | (condex_r_q & (branch | (reg_w & (rd == 4'hF)))));
  assign RegWrite   = reset & reg_w & condex_r_q;
  assign MemWrite   = reset & mem_w & condex_r_q;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign ALUControl = ALUCTRL_W'(exec ? alu_op : 3'd0);
  assign State      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller against an instruction-level model
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        MemReq, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  mc_controller #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .MemReq(MemReq), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .State(State)
  );

  always #5 clk = ~clk;

  logic [4:0] strobes;
  logic [9:0] sels;
  assign strobes = {MemReq, IRWrite, PCWrite, RegWrite, MemWrite};
  assign sels    = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc};

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  m_flags  = 4'b0000;
  logic [19:0] ins;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] & ~f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] f);
    case (f)
      4'b0010, 4'b1010: return 3'd1;
      4'b0000:          return 3'd2;
      4'b1100:          return 3'd3;
      4'b0001:          return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic [9:0] sel(input logic a, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] res, input logic [1:0] imm, input logic [1:0] rg);
    return {a, sa, sb, res, imm, rg};
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  task automatic cycle(input string tag, input logic [19:0] i, input logic rdy, input logic [3:0] fl,
                       input logic [3:0] es, input logic [4:0] est, input logic [9:0] esel,
                       input logic [2:0] ealu);
    @(negedge clk);
    Instr    = i;
    MemReady = rdy;
    ALUFlags = fl;
    #1;
    chk({tag, ".state"}, State, es);
    chk({tag, ".strobes"}, strobes, est);
    chk({tag, ".sel"}, sels, esel);
    chk({tag, ".aluctl"}, ALUControl, ealu);
  endtask

  task automatic run_instr(input logic [19:0] i, input int fwait, input int mwait, input logic [3:0] exf);
    logic [3:0] cond, rd;
    logic [1:0] op, rs;
    logic [5:0] funct;
    logic       cx, cmp, arith, rw;
    cond  = i[19:16];
    op    = i[15:14];
    funct = i[13:8];
    rd    = i[3:0];
    rs    = {op == 2'b01, op == 2'b10};
    cx    = cond_holds(cond, m_flags);
    cmp   = (funct[4:1] == 4'b1010);
    arith = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) || cmp;
    for (int w = 0; w <= fwait; w++)
      cycle("fetch", i, w == fwait, rnd4(), 4'd0, {1'b1, w == fwait, w == fwait, 2'b00},
            sel(0, 1, 2'b10, 2'b10, 2'b00, rs), 3'd0);
    cycle("decode", i, 1'($urandom), rnd4(), 4'd1, 5'b0, sel(0, 1, 2'b10, 2'b10, 2'b00, rs), 3'd0);
    case (op)
      2'b00: begin
        cycle("exec", i, 1'($urandom), exf, funct[5] ? 4'd7 : 4'd6, 5'b0,
              sel(0, 0, funct[5] ? 2'b01 : 2'b00, 2'b00, 2'b00, rs), alu_code(funct[4:1]));
        if (cx) begin
          if (cmp) m_flags = exf;
          else begin
            if (funct[0]) m_flags[3:2] = exf[3:2];
            if (funct[0] && arith) m_flags[1:0] = exf[1:0];
          end
        end
        rw = cx & ~cmp;
        cycle("aluwb", i, 1'($urandom), rnd4(), 4'd8, {2'b00, rw & (rd == 4'hF), rw, 1'b0},
              sel(0, 0, 2'b00, 2'b00, 2'b00, rs), 3'd0);
      end
      2'b01: begin
        cycle("memadr", i, 1'($urandom), rnd4(), 4'd2, 5'b0, sel(0, 0, 2'b01, 2'b00, 2'b01, rs), 3'd0);
        if (funct[0]) begin
          for (int w = 0; w <= mwait; w++)
            cycle("memrd", i, w == mwait, rnd4(), 4'd3, 5'b10000, sel(1, 0, 2'b00, 2'b00, 2'b00, rs), 3'd0);
          cycle("memwb", i, 1'($urandom), rnd4(), 4'd4, {2'b00, cx & (rd == 4'hF), cx, 1'b0},
                sel(0, 0, 2'b00, 2'b01, 2'b00, rs), 3'd0);
        end else begin
          for (int w = 0; w <= mwait; w++)
            cycle("memwr", i, w == mwait, rnd4(), 4'd5, {4'b1000, cx}, sel(1, 0, 2'b00, 2'b00, 2'b00, rs), 3'd0);
        end
      end
      2'b10: cycle("branch", i, 1'($urandom), rnd4(), 4'd9, {2'b00, cx, 2'b00},
                   sel(0, 0, 2'b01, 2'b10, 2'b10, rs), 3'd0);
      default: ;
    endcase
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    MemReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("reset.state", State, 4'd0);
      chk("reset.strobes", strobes, 5'b0);
    end
    reset    = 1'b1;
    MemReady = 1'b0;

    run_instr({4'hE, 2'b00, 6'b001000, 4'h2, 4'h1}, 0, 0, rnd4());
    run_instr({4'hE, 2'b01, 6'b011001, 4'h3, 4'h2}, 1, 3, rnd4());
    run_instr({4'hE, 2'b00, 6'b100101, 4'h0, 4'h0}, 0, 0, 4'b0100);
    run_instr({4'h0, 2'b10, 6'b100000, 4'h0, 4'h0}, 0, 0, rnd4());
    run_instr({4'hE, 2'b00, 6'b100101, 4'h0, 4'h0}, 0, 0, 4'b0010);
    run_instr({4'h0, 2'b10, 6'b100000, 4'h0, 4'h0}, 0, 0, rnd4());
    run_instr({4'hE, 2'b00, 6'b010101, 4'h1, 4'h0}, 0, 0, 4'b0110);
    run_instr({4'h1, 2'b00, 6'b001000, 4'h1, 4'h1}, 0, 0, rnd4());
    run_instr({4'hE, 2'b00, 6'b001000, 4'h1, 4'hF}, 0, 0, rnd4());

    ins = {4'hE, 2'b01, 6'b011000, 4'h1, 4'h3};
    cycle("str.fetch", ins, 1'b1, rnd4(), 4'd0, 5'b11100, sel(0, 1, 2'b10, 2'b10, 2'b00, 2'b10), 3'd0);
    cycle("str.decode", ins, 1'b0, rnd4(), 4'd1, 5'b0, sel(0, 1, 2'b10, 2'b10, 2'b00, 2'b10), 3'd0);
    cycle("str.memadr", ins, 1'b0, rnd4(), 4'd2, 5'b0, sel(0, 0, 2'b01, 2'b00, 2'b01, 2'b10), 3'd0);
    for (int k = 0; k < 5; k++)
      cycle("str.hold", ins, 1'b0, rnd4(), 4'd5, 5'b10001, sel(1, 0, 2'b00, 2'b00, 2'b00, 2'b10), 3'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      reset    = 1'b0;
      MemReady = 1'b0;
      #1;
      chk("str.rst.state", State, 4'd0);
      chk("str.rst.strobes", strobes, 5'b0);
    end
    m_flags  = 4'b0000;
    reset    = 1'b1;
    run_instr({4'h0, 2'b00, 6'b001000, 4'h1, 4'h4}, 0, 0, rnd4());
    run_instr({4'h1, 2'b00, 6'b001000, 4'h1, 4'h4}, 0, 0, rnd4());

    for (int k = 0; k < 120; k++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), rnd4());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
